// File: rtl/br_write_sched.sv
// br_write_sched: write-port scheduler and scoreboard for the 32x32 register bank.
// Two writeback requesters share the bank's single write port through a
// round-robin arbiter followed by a one-cycle registered write stage. A
// reservation bitmap lets decode detect read-after-write hazards, including the
// one-cycle window where a write sits in the output stage before the bank commits.
// Optional build macro: ZERO_REG_PROTECT_EN makes register 0 a read-only zero.
// With it, writes and claims to address 0 are accepted but have no effect, and
// hazards on address 0 are suppressed.
module br_write_sched #(
  parameter  int DATA_W = 32,
  parameter  int ADDR_W = 5,
  localparam int NREG   = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              claim_valid,
  input  logic [ADDR_W-1:0] claim_addr,
  input  logic              flush,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic              hazard1,
  output logic              hazard2,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] DE,
  output logic [DATA_W-1:0] DatoIn,
  output logic [NREG-1:0]   busy_map
);

  // last_grant_reg = 1 means requester 1 won most recently, so requester 0 wins the next tie
  logic              last_grant_reg, last_grant_next;
  logic              grant0, grant1, xfer;
  logic [ADDR_W-1:0] xfer_addr;
  logic [DATA_W-1:0] xfer_data;
  logic              wr_en, claim_en;
  logic              regwrite_reg;
  logic [ADDR_W-1:0] de_reg;
  logic [DATA_W-1:0] dato_reg;
  logic [NREG-1:0]   busy_reg, busy_next;
  logic              hz1_raw, hz2_raw;

  // Round-robin arbitration: a lone requester always wins, a tie goes to the one not served last
  always_comb begin
    grant0          = req0_valid && (!req1_valid || last_grant_reg);
    grant1          = req1_valid && (!req0_valid || !last_grant_reg);
    xfer            = grant0 || grant1;
    xfer_addr       = grant1 ? req1_addr : req0_addr;
    xfer_data       = grant1 ? req1_data : req0_data;
    last_grant_next = last_grant_reg;
    if (grant0) last_grant_next = 1'b0;
    if (grant1) last_grant_next = 1'b1;
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

`ifdef ZERO_REG_PROTECT_EN
  // Register 0 is hardwired: its writes handshake but are dropped, its claims are ignored
  assign wr_en    = xfer && (xfer_addr != '0);
  assign claim_en = claim_valid && (claim_addr != '0);
`else
  assign wr_en    = xfer;
  assign claim_en = claim_valid;
`endif

  // Arbiter history only advances on an actual transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_grant_reg <= 1'b1;
    else        last_grant_reg <= last_grant_next;
  end

  // Registered write stage; address and data hold their last values between writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regwrite_reg <= 1'b0;
      de_reg       <= '0;
      dato_reg     <= '0;
    end else begin
      regwrite_reg <= wr_en;
      if (wr_en) begin
        de_reg   <= xfer_addr;
        dato_reg <= xfer_data;
      end
    end
  end

  assign RegWrite = regwrite_reg;
  assign DE       = de_reg;
  assign DatoIn   = dato_reg;

  // Per-register next state: flush beats everything, a new claim beats a completing write
  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_busy
      assign busy_next[gi] = flush                                          ? 1'b0 :
                             (claim_en && (claim_addr == ADDR_W'(gi)))      ? 1'b1 :
                             (xfer && (xfer_addr == ADDR_W'(gi)))           ? 1'b0 :
                             busy_reg[gi];
    end
  endgenerate

  // Reservation bitmap register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_reg <= '0;
    else        busy_reg <= busy_next;
  end

  assign busy_map = busy_reg;

  // Hazard = reserved, or being written to the bank this very cycle
  always_comb begin
    hz1_raw = busy_reg[rd_addr1] | (regwrite_reg && (de_reg == rd_addr1));
    hz2_raw = busy_reg[rd_addr2] | (regwrite_reg && (de_reg == rd_addr2));
`ifdef ZERO_REG_PROTECT_EN
    hazard1 = hz1_raw && (rd_addr1 != '0);
    hazard2 = hz2_raw && (rd_addr2 != '0);
`else
    hazard1 = hz1_raw;
    hazard2 = hz2_raw;
`endif
  end

endmodule

// File: doc/br_write_sched.md
Name: br_write_sched

Overview:
- Write-port scheduler and scoreboard for the 32x32 register bank.
- Arbitrates two writeback requesters onto the bank's single write port (RegWrite/DE/DatoIn).
- Tracks registers with outstanding writes so decode can stall on read-after-write hazards.
- Sits between the execute/memory writeback sources and the register bank.

Parameters:
- DATA_W, 32, width of write data
- ADDR_W, 5, register address width; NREG = 2**ADDR_W entries tracked

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req0_valid  input  1  requester 0 (ALU writeback) has a write
- req0_addr  input  ADDR_W  requester 0 destination register
- req0_data  input  DATA_W  requester 0 write data
- req0_ready  output  1  requester 0 write accepted this cycle
- req1_valid  input  1  requester 1 (memory/load writeback) has a write
- req1_addr  input  ADDR_W  requester 1 destination register
- req1_data  input  DATA_W  requester 1 write data
- req1_ready  output  1  requester 1 write accepted this cycle
- claim_valid  input  1  issue stage reserves a destination register
- claim_addr  input  ADDR_W  register being reserved
- flush  input  1  clear all reservations (pipeline flush)
- rd_addr1  input  ADDR_W  decode source operand 1 (mirrors AR1)
- rd_addr2  input  ADDR_W  decode source operand 2 (mirrors AR2)
- hazard1  output  1  rd_addr1 has an outstanding write
- hazard2  output  1  rd_addr2 has an outstanding write
- RegWrite  output  1  to bank write enable
- DE  output  ADDR_W  to bank write address
- DatoIn  output  DATA_W  to bank write data
- busy_map  output  NREG  current reservation bitmap

Behaviour:
- Reset (async, rst_n=0): RegWrite=0, DE=0, DatoIn=0, busy_map=0, last_grant=1 (requester 0 wins first tie).
- Handshake: transfer occurs when valid && ready at a rising edge. ready is combinational from valid and last_grant. Requester holds valid/addr/data stable until ready. At most one ready high per cycle.
- Arbitration, round-robin:
  - Only one valid: grant it.
  - Both valid: grant the requester not equal to last_grant.
  - last_grant updates only on a transfer.
- Write port is a registered stage, latency 1. A transfer at edge N drives RegWrite=1 with DE/DatoIn = granted addr/data during cycle N+1. The bank commits at edge N+1.
- No transfer: RegWrite=0 next cycle; DE/DatoIn hold their last values.
- Back-to-back transfers every cycle are supported (full throughput, no bubbles).
- Scoreboard, updated at each rising edge:
  - Transfer to addr A clears busy[A].
  - claim_valid sets busy[claim_addr].
  - Claim and clear of the same address in the same cycle: set wins (new reservation).
  - flush: busy_map becomes 0 in the next cycle. A claim in the same cycle as flush is dropped. flush does not affect arbitration or the write stage.
  - Claim of an already-busy register: stays 1, no error.
- Hazards: hazard1 = busy_map[rd_addr1] | (RegWrite && DE==rd_addr1); hazard2 likewise. Combinational. Covers the one-cycle window before the bank commits.
- Reset mid-operation: pending output-stage write is discarded (RegWrite forced 0 immediately); reservations lost.

Optional Feature:
- ZERO_REG_PROTECT_EN
- Defined:
  - Register 0 is read-only zero.
  - Transfers to addr 0 still handshake (ready=1) but produce RegWrite=0.
  - Claims of addr 0 are ignored; busy_map[0] stays 0.
  - hazard1/hazard2 are 0 whenever the address is 0.
- Undefined: addr 0 is treated like any other register.

Test Plan:
- Reset then idle: RegWrite=0, DE=0, DatoIn=0, busy_map=0, hazard1=hazard2=0.
- req0 alone, addr=5, data=0x0000_00AA: req0_ready=1 at edge N; RegWrite=1, DE=5, DatoIn=0xAA at cycle N+1; RegWrite=0 at N+2.
- Both valid for 4 cycles (req0 addr 1 data 0x11, req1 addr 2 data 0x22): grants alternate 0,1,0,1; DE sequence 1,2,1,2 with RegWrite high 4 consecutive cycles.
- claim addr 7, rd_addr1=7: hazard1=1 next cycle. req1 writes addr 7: busy_map[7]=0 after transfer edge; hazard1 stays 1 during the RegWrite cycle, then 0.
- Same cycle: claim addr 3 and transfer to addr 3 → busy_map[3]=1. Then flush with claim addr 4 → busy_map=0.
- With ZERO_REG_PROTECT_EN: req0 addr 0 data 0xFFFF_FFFF → req0_ready=1, RegWrite stays 0; claim addr 0 → busy_map[0]=0, hazard1=0 for rd_addr1=0.
